decoder_sequencer: RTL and testbench

- Command sequencer directly upstream of the team's one-hot decoder.
- Accepts {select, data, dwell} commands over a valid/ready handshake and buffers them in a small FIFO.
- Replays each command on registered select/data outputs for a programmed number of cycles, back-to-back, so the decoder downstream sees stable, glitch-free inputs.
- Drives activity and completion flags for the surrounding control logic.

---
 rtl/decoder_sequencer.sv | 151 +++++++++++++++
 tb/tb_decoder_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_sequencer.sv
// Command sequencer feeding the one-hot decoder: buffers {select, data, dwell}
// commands and replays each on registered outputs for dwell+1 cycles.
module decoder_sequencer #(
    parameter int WIDTH   = 3,
    parameter int DEPTH   = 4,
    parameter int DWELL_W = 8
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [WIDTH-1:0]           cmd_select,
    input  logic [WIDTH-1:0]           cmd_data,
    input  logic [DWELL_W-1:0]         cmd_dwell,
    output logic [WIDTH-1:0]           select,
    output logic [WIDTH-1:0]           data,
    output logic                       active,
    output logic                       done,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0]   sel;
        logic [WIDTH-1:0]   dat;
        logic [DWELL_W-1:0] dwell;
    } cmd_t;

    cmd_t               mem [DEPTH];
    cmd_t               head;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               push;
    logic               pop;

    state_t             state;
    state_t             state_nxt;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] cnt_nxt;
    logic [WIDTH-1:0]   select_nxt;
    logic [WIDTH-1:0]   data_nxt;
    logic               active_nxt;

    // Ready depends only on the registered level, so a pop never opens it early.
    assign cmd_ready = (level != FULL);
    assign push      = cmd_valid && cmd_ready;
    assign head      = mem[rd_ptr];

    // Command storage; contents need no reset because level gates every read.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= '{sel: cmd_select, dat: cmd_data, dwell: cmd_dwell};
        end
    end

    // FIFO pointers and occupancy; a push and pop together leave level alone.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and pop decision; the next command loads straight from HOLD.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        unique case (state)
            IDLE: begin
                if (level != '0) begin
                    pop       = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    if (level != '0) begin
                        pop = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
        endcase
    end

    // Output decode: done marks the last presented cycle, the rest are next values.
    always_comb begin
        done       = (state == HOLD) && (cnt == '0);
        select_nxt = select;
        data_nxt   = data;
        cnt_nxt    = cnt;
        active_nxt = (state_nxt == HOLD);
        if (pop) begin
            select_nxt = head.sel;
            data_nxt   = head.dat;
            cnt_nxt    = head.dwell;
        end else if (state == HOLD && cnt != '0) begin
            cnt_nxt = cnt - DWELL_W'(1);
        end else if (state == HOLD) begin
            select_nxt = '0;
            data_nxt   = '0;
        end
    end

    // Registered decoder-facing outputs and dwell counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            select <= '0;
            data   <= '0;
            cnt    <= '0;
            active <= 1'b0;
        end else begin
            select <= select_nxt;
            data   <= data_nxt;
            cnt    <= cnt_nxt;
            active <= active_nxt;
        end
    end

endmodule

// File: tb/tb_decoder_sequencer.sv
// Self-checking bench for decoder_sequencer: cycle tables, corner sequences
// and a scoreboard tracking order, duration and done pulses of every command.
module tb_decoder_sequencer;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_select;
    logic [2:0] cmd_data;
    logic [7:0] cmd_dwell;
    logic [2:0] select;
    logic [2:0] data;
    logic       active;
    logic       done;
    logic [2:0] level;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] s;
        logic [2:0] d;
        logic [7:0] w;
    } cmd_t;

    typedef struct {
        logic       v;
        logic [2:0] s;
        logic [2:0] d;
        logic [7:0] w;
        logic [2:0] es;
        logic [2:0] ed;
        logic       ea;
        logic       edn;
        logic [2:0] el;
        logic       er;
    } vec_t;

    cmd_t sb[$];
    vec_t tbl[$];
    int   run_cnt = 0;
    int   done_total = 0;

    decoder_sequencer #(
        .WIDTH(3),
        .DEPTH(4),
        .DWELL_W(8)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_select(cmd_select),
        .cmd_data(cmd_data),
        .cmd_dwell(cmd_dwell),
        .select(select),
        .data(data),
        .active(active),
        .done(done),
        .level(level)
    );

    always #5 clock = ~clock;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic vec_t mk(logic v, logic [2:0] s, logic [2:0] d,
                                logic [7:0] w, logic [2:0] es, logic [2:0] ed,
                                logic ea, logic edn, logic [2:0] el, logic er);
        vec_t r;
        r.v = v; r.s = s; r.d = d; r.w = w;
        r.es = es; r.ed = ed; r.ea = ea; r.edn = edn; r.el = el; r.er = er;
        return r;
    endfunction

    // Record every accepted command in arrival order.
    always @(posedge clock) begin
        if (reset_n && cmd_valid && cmd_ready) begin
            sb.push_back('{cmd_select, cmd_data, cmd_dwell});
        end
    end

    // Check presented commands against the scoreboard head.
    always @(negedge clock) begin
        if (!reset_n) begin
            sb.delete();
            run_cnt = 0;
        end else if (active) begin
            if (sb.size() == 0) begin
                chk("mon_unexpected_active", 32'(select), 32'hffff_ffff);
            end else begin
                chk("mon_sel", 32'(select), 32'(sb[0].s));
                chk("mon_data", 32'(data), 32'(sb[0].d));
                chk("mon_done", 32'(done), 32'(run_cnt == int'(sb[0].w)));
                run_cnt++;
                if (done) begin
                    void'(sb.pop_front());
                    run_cnt = 0;
                    done_total++;
                end
            end
        end else begin
            chk("mon_idle_out", {29'd0, done, select == 3'd0, data == 3'd0}, 32'd3);
        end
    end

    task automatic drive(logic v, logic [2:0] s, logic [2:0] d, logic [7:0] w);
        cmd_valid  = v;
        cmd_select = s;
        cmd_data   = d;
        cmd_dwell  = w;
    endtask

    task automatic run_rows(string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].w);
            @(negedge clock);
            chk({tag, "_sel"}, 32'(select), 32'(tbl[i].es));
            chk({tag, "_data"}, 32'(data), 32'(tbl[i].ed));
            chk({tag, "_active"}, 32'(active), 32'(tbl[i].ea));
            chk({tag, "_done"}, 32'(done), 32'(tbl[i].edn));
            chk({tag, "_level"}, 32'(level), 32'(tbl[i].el));
            chk({tag, "_ready"}, 32'(cmd_ready), 32'(tbl[i].er));
        end
        drive(1'b0, 3'd0, 3'd0, 8'd0);
    endtask

    task automatic wait_idle(string name, int budget);
        int n = 0;
        #1;
        while ((sb.size() != 0 || active || level != 3'd0) && n < budget) begin
            @(negedge clock);
            #1;
            n++;
        end
        chk(name, 32'(sb.size() == 0 && !active && level == 3'd0), 32'd1);
        @(negedge clock);
    endtask

    task automatic single_cmd(string tag);
        tbl.delete();
        tbl.push_back(mk(1, 5, 3, 2, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 5, 3, 1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 5, 3, 1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 5, 3, 1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        run_rows(tag);
    endtask

    initial begin
        int base;
        int sent;
        int guard;
        int n;
        reset_n = 1'b0;
        drive(1'b0, 3'd0, 3'd0, 8'd0);
        #2;
        chk("reset_out", {26'd0, select, data}, 32'd0);
        chk("reset_flags", {29'd0, active, done, level != 3'd0}, 32'd0);
        repeat (2) @(posedge clock);
        #2 reset_n = 1'b1;

        // Idle after reset.
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            chk("idle_out", {24'd0, select, data, active, done}, 32'd0);
            chk("idle_ready_level", {28'd0, cmd_ready, level}, 32'h8);
        end

        single_cmd("single");

        // Back-to-back commands with no gap.
        tbl.delete();
        tbl.push_back(mk(1, 1, 7, 0, 0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1, 2, 6, 1, 1, 7, 1, 1, 1, 1));
        tbl.push_back(mk(1, 4, 5, 0, 2, 6, 1, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 2, 6, 1, 1, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 4, 5, 1, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        base = done_total;
        run_rows("b2b");
        chk("b2b_done_count", 32'(done_total - base), 32'd3);

        // Full FIFO while a long dwell stalls the drain.
        drive(1'b1, 3'd6, 3'd1, 8'd255);
        @(negedge clock);
        drive(1'b0, 3'd0, 3'd0, 8'd0);
        @(negedge clock);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'(i), 3'(i + 1), 8'd0);
            @(negedge clock);
        end
        drive(1'b1, 3'd7, 3'd7, 8'd0);
        chk("full_level", 32'(level), 32'd4);
        chk("full_ready", 32'(cmd_ready), 32'd0);
        @(negedge clock);
        drive(1'b0, 3'd0, 3'd0, 8'd0);
        chk("full_reject_level", 32'(level), 32'd4);
        n = 0;
        while (level == 3'd4 && n < 300) begin
            @(negedge clock);
            n++;
        end
        chk("full_first_pop_level", 32'(level), 32'd3);
        chk("full_first_pop_ready", 32'(cmd_ready), 32'd1);
        chk("full_first_pop_sel", 32'(select), 32'd0);
        chk("full_first_pop_data", 32'(data), 32'd1);
        wait_idle("full_drain", 50);

        // Asynchronous reset mid-HOLD with two queued commands.
        drive(1'b1, 3'd3, 3'd2, 8'd10);
        @(negedge clock);
        drive(1'b1, 3'd1, 3'd1, 8'd1);
        @(negedge clock);
        drive(1'b1, 3'd2, 3'd2, 8'd2);
        @(negedge clock);
        drive(1'b0, 3'd0, 3'd0, 8'd0);
        repeat (2) @(negedge clock);
        chk("rst_pre_level", 32'(level), 32'd2);
        chk("rst_pre_sel", 32'(select), 32'd3);
        base = done_total;
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_async_out", {26'd0, select, data}, 32'd0);
        chk("rst_async_flags", {30'd0, active, done}, 32'd0);
        chk("rst_async_level", 32'(level), 32'd0);
        @(negedge clock);
        @(posedge clock);
        #2 reset_n = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst_no_done", 32'(done_total - base), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        single_cmd("post_rst");

        // Random stream of 200 commands.
        base  = done_total;
        sent  = 0;
        guard = 0;
        while (sent < 200 && guard < 20000) begin
            @(negedge clock);
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 8'($urandom_range(0, 7)));
            if (cmd_valid && cmd_ready) sent++;
            guard++;
        end
        chk("rand_sent", 32'(sent), 32'd200);
        @(negedge clock);
        drive(1'b0, 3'd0, 3'd0, 8'd0);
        wait_idle("rand_drain", 2000);
        chk("rand_done_count", 32'(done_total - base), 32'd200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
